// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned CtrlStateW = 2;

    // Encodings are visible on the debug port, so they are fixed explicitly.
    typedef enum logic [CtrlStateW-1:0] {
        StRun     = 2'd0,
        StIwait   = 2'd1,
        StDwait   = 2'd2,
        StDiscard = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_use_rs2,
    output logic                  load_use
);

    logic rd_nonzero;
    logic hit_rs1;
    logic hit_rs2;

    // x0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        rd_nonzero = (idex_rd != '0);
        hit_rs1    = (idex_rd == ifid_rs1);
        hit_rs2    = ifid_use_rs2 && (idex_rd == ifid_rs2);
        load_use   = idex_memread && rd_nonzero && (hit_rs1 || hit_rs2);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with saturating stall and flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_use_rs2,
    input  logic                  idex_memread,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic                  branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_busy,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  pipe_freeze,
    output logic [1:0]            ctrl_state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             load_use;
    logic             redirect;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_load_use_detect (
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs2(ifid_use_rs2),
        .load_use    (load_use)
    );

    // Fixed-priority decode of hazards into pipeline controls and next state.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        redirect    = 1'b0;
        state_d     = state_q;

        if (rst) begin
            state_d = StRun;
        end else if (state_q == StDiscard) begin
            // Wrong-path fetch still outstanding; the branch input has no valid source here.
            ifid_flush  = 1'b1;
            pipe_freeze = dmem_busy;
            state_d     = imem_ready ? StRun : StDiscard;
        end else if (dmem_busy) begin
            // EX is held, so any branch resolution there is not yet real.
            pipe_freeze = 1'b1;
            state_d     = StDwait;
        end else if (branch_taken) begin
            pc_write   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            redirect   = 1'b1;
            state_d    = imem_ready ? StRun : StDiscard;
        end else if (load_use) begin
            idex_flush = 1'b1;
            state_d    = StRun;
        end else if (!imem_ready) begin
            ifid_flush = 1'b1;
            state_d    = StIwait;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            state_d    = StRun;
        end
    end

    // Saturating counter next-state.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!rst && !pc_write && (stall_q != CntMax)) begin
            stall_d = stall_q + 1'b1;
        end
        if (redirect && (flush_q != CntMax)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Debug and counter outputs read as idle while reset is held.
    always_comb begin
        ctrl_state = rst ? StRun : state_q;
        stall_cnt  = rst ? '0 : stall_q;
        flush_cnt  = rst ? '0 : flush_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle behavioural model plus directed literal checks.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] ifid_rs1 = '0;
    logic [4:0] ifid_rs2 = '0;
    logic       ifid_use_rs2 = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rd = '0;
    logic       branch_taken = 1'b0;
    logic       imem_ready = 1'b1;
    logic       dmem_busy = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_flush, s_pipe_freeze;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: pipeline mode as a plain int (0 run, 1 iwait, 2 dwait, 3 discard) and raw counts.
    int     m_mode = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDR_W(5),
        .CNT_W     (32)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .branch_taken(branch_taken),
        .imem_ready  (imem_ready),
        .dmem_busy   (dmem_busy),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .pipe_freeze (pipe_freeze),
        .ctrl_state  (ctrl_state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    pipe_hazard_ctrl #(
        .REG_ADDR_W(5),
        .CNT_W     (4)
    ) u_sat (
        .clk         (clk),
        .rst         (rst),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2),
        .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread),
        .idex_rd     (idex_rd),
        .branch_taken(branch_taken),
        .imem_ready  (imem_ready),
        .dmem_busy   (dmem_busy),
        .pc_write    (s_pc_write),
        .ifid_write  (s_ifid_write),
        .ifid_flush  (s_ifid_flush),
        .idex_flush  (s_idex_flush),
        .pipe_freeze (s_pipe_freeze),
        .ctrl_state  (s_ctrl_state),
        .stall_cnt   (s_stall_cnt),
        .flush_cnt   (s_flush_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint max);
        return (v > max) ? max : v;
    endfunction

    // Model: expected outputs this cycle from the hazard rules, then advance model state.
    always @(negedge clk) begin
        logic e_pc, e_ifw, e_iff, e_idf, e_frz, hazard, redirect;
        int   nxt;
        e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_frz = 0; redirect = 0;
        nxt = m_mode;
        hazard = idex_memread && (idex_rd != 0) &&
                 ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));
        if (!rst) begin
            if (m_mode == 3) begin
                e_iff = 1; e_frz = dmem_busy;
                nxt = imem_ready ? 0 : 3;
            end else if (dmem_busy) begin
                e_frz = 1; nxt = 2;
            end else if (branch_taken) begin
                e_pc = 1; e_iff = 1; e_idf = 1; redirect = 1;
                nxt = imem_ready ? 0 : 3;
            end else if (hazard) begin
                e_idf = 1; nxt = 0;
            end else if (!imem_ready) begin
                e_iff = 1; nxt = 1;
            end else begin
                e_pc = 1; e_ifw = 1; nxt = 0;
            end
        end
        check("pc_write",    pc_write,    e_pc);
        check("ifid_write",  ifid_write,  e_ifw);
        check("ifid_flush",  ifid_flush,  e_iff);
        check("idex_flush",  idex_flush,  e_idf);
        check("pipe_freeze", pipe_freeze, e_frz);
        check("ctrl_state",  ctrl_state,  rst ? 0 : m_mode);
        check("stall_cnt",   stall_cnt,   rst ? 0 : sat(m_stall, 64'hFFFF_FFFF));
        check("flush_cnt",   flush_cnt,   rst ? 0 : sat(m_flush, 64'hFFFF_FFFF));
        check("sat_pc_write", s_pc_write, e_pc);
        check("sat_ctrl",    s_ctrl_state, rst ? 0 : m_mode);
        check("sat_stall",   s_stall_cnt, rst ? 0 : sat(m_stall, 15));
        check("sat_flush",   s_flush_cnt, rst ? 0 : sat(m_flush, 15));
        if (rst) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_mode = nxt;
            if (!e_pc) m_stall++;
            if (redirect) m_flush++;
        end
    end

    // One pipeline cycle of stimulus; returns at the following negedge so callers can check.
    task automatic cyc(input logic bt, input logic ir, input logic db, input logic mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u2);
        @(posedge clk); #1;
        rst = 0; branch_taken = bt; imem_ready = ir; dmem_busy = db;
        idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_use_rs2 = u2;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            rst = 1;
            branch_taken = 1'($urandom); imem_ready = 1'($urandom); dmem_busy = 1'($urandom);
            idex_memread = 1'($urandom); idex_rd = 5'($urandom); ifid_rs1 = 5'($urandom);
            ifid_rs2 = 5'($urandom); ifid_use_rs2 = 1'($urandom);
            @(negedge clk);
            check("rst_ctrl", {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}, 0);
            check("rst_cnt", {stall_cnt, flush_cnt}, 0);
            check("rst_state", ctrl_state, 0);
        end
    endtask

    initial begin
        // Reset with random inputs.
        do_reset();

        // Load-use on rs1.
        cyc(0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        check("lu_ctrl", {pc_write, ifid_write, idex_flush}, 3'b001);
        idle();
        check("lu_stall", stall_cnt, 1);
        // rd = x0: no stall.
        cyc(0, 1, 0, 1, 5'd0, 5'd0, 5'd0, 0);
        check("lu_x0", {pc_write, ifid_write, idex_flush}, 3'b110);
        // rs2 matches but is not read: no stall.
        cyc(0, 1, 0, 1, 5'd5, 5'd3, 5'd5, 0);
        check("lu_nors2", {pc_write, ifid_write, idex_flush}, 3'b110);
        // rs2 matches and is read: stall.
        cyc(0, 1, 0, 1, 5'd5, 5'd3, 5'd5, 1);
        check("lu_rs2", {pc_write, ifid_write, idex_flush}, 3'b001);
        // Load-use beats an IMEM miss: no NOP injection this cycle.
        cyc(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0);
        check("lu_vs_miss", {pc_write, ifid_flush, idex_flush}, 3'b001);
        // Branch beats load-use.
        cyc(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        check("br_vs_lu", {pc_write, ifid_flush, idex_flush}, 3'b111);
        idle();
        check("br_vs_lu_cnt", flush_cnt, 1);

        // Branch with fetch pending -> three DISCARD cycles.
        do_reset();
        cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("brp_pc", pc_write, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, (i == 2), 0, 0, 5'd0, 5'd0, 5'd0, 0);
            check("disc_state", ctrl_state, 3);
            check("disc_flush", {pc_write, ifid_flush, idex_flush}, 3'b010);
        end
        idle();
        check("brp_state", ctrl_state, 0);
        check("brp_flush", flush_cnt, 1);
        check("brp_stall", stall_cnt, 3);

        // DISCARD with data busy: freeze, and exit on imem_ready without waiting for busy.
        do_reset();
        cyc(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        check("disc_busy", {pc_write, ifid_flush, idex_flush, pipe_freeze}, 4'b0101);
        cyc(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        check("disc_exit_state", ctrl_state, 0);
        check("disc_exit_frz", pipe_freeze, 1);
        check("disc_flush_cnt", flush_cnt, 1);

        // DMEM wait holds a pending branch.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
            check("dw_frz", {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze}, 5'b00001);
            check("dw_fcnt", flush_cnt, 0);
            if (i > 0) check("dw_state", ctrl_state, 2);
        end
        cyc(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        check("dw_br", {pc_write, ifid_flush, idex_flush}, 3'b111);
        idle();
        check("dw_fcnt_after", flush_cnt, 1);
        check("dw_stall", stall_cnt, 4);

        // IMEM miss for two cycles.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            check("im_ctrl", {pc_write, ifid_write, ifid_flush}, 3'b001);
            if (i > 0) check("im_state", ctrl_state, 1);
        end
        idle();
        check("im_state_w", ctrl_state, 1);
        check("im_norm", {pc_write, ifid_write, ifid_flush}, 3'b110);
        idle();
        check("im_back", ctrl_state, 0);
        check("im_stall", stall_cnt, 2);

        // Saturation: 20 stall cycles on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        check("sat_hold", s_stall_cnt, 15);
        check("sat_wide", stall_cnt, 20);
        idle();
        check("sat_hold2", s_stall_cnt, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
